// File: rtl/csa_final_adder_seq_if.sv
// Operand/result handshake bundle for csa_final_adder_seq.
//   master : upstream producer + downstream consumer side (drives in_valid,
//            sum_in, carry_in, out_ready; observes in_ready, out_valid,
//            result, busy)
//   slave  : the adder itself
// WIDTH is the CSA vector width; result is WIDTH+2 bits.
interface csa_final_adder_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;
    logic             busy;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_final_adder_seq.sv
// Final carry-propagate adder behind a carry-save stage:
//     result = sum_in + (carry_in << 1)
// resolved CHUNK bits per clock with the chunk carry held in a register.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       csa_final_adder_seq_if.slave: in_valid/in_ready/sum_in/carry_in,
//             out_valid/out_ready/result, busy
//   op_count  (only with CSA_FINAL_ADDER_STATS_EN defined) 16-bit wrapping
//             count of completed output handshakes
// Optional feature macro: CSA_FINAL_ADDER_STATS_EN.
module csa_final_adder_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csa_final_adder_seq_if.slave  bus
`ifdef CSA_FINAL_ADDER_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned RES_W  = WIDTH + 2;

    if ((WIDTH % CHUNK) != 0) begin : g_param_chk
        $error("csa_final_adder_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               top_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [RES_W-1:0]   result_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [CHUNK-1:0]   a_chunk_c;
    logic [CHUNK-1:0]   b_chunk_c;
    logic [CHUNK:0]     chunk_sum_c;
    logic               last_chunk_c;

    // Select the active operand chunk and add it with the held carry.
    always_comb begin
        a_chunk_c = '0;
        b_chunk_c = '0;
        for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_chunk_c = a_q[k*CHUNK +: CHUNK];
                b_chunk_c = b_q[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum_c  = (CHUNK+1)'(a_chunk_c) + (CHUNK+1)'(b_chunk_c)
                     + (CHUNK+1)'(carry_q);
        last_chunk_c = (idx_q == IDX_W'(NCHUNK - 1));
    end

    // Control FSM plus operand/result datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            top_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // carry vector bit i weighs 2^(i+1): shift it into B and
                        // keep the bit that falls off as the top contribution.
                        a_q         <= bus.sum_in;
                        b_q         <= {bus.carry_in[WIDTH-2:0], 1'b0};
                        top_q       <= bus.carry_in[WIDTH-1];
                        result_q    <= '0;
                        carry_q     <= 1'b0;
                        idx_q       <= '0;
                        state_q     <= S_BUSY;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                S_BUSY: begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            result_q[k*CHUNK +: CHUNK] <= chunk_sum_c[CHUNK-1:0];
                        end
                    end
                    carry_q <= chunk_sum_c[CHUNK];
                    if (last_chunk_c) begin
                        // top bit and final carry-out both land on weight 2^WIDTH
                        result_q[WIDTH]   <= top_q ^ chunk_sum_c[CHUNK];
                        result_q[WIDTH+1] <= top_q & chunk_sum_c[CHUNK];
                        idx_q             <= '0;
                        state_q           <= S_DONE;
                        busy_q            <= 1'b0;
                        out_valid_q       <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

`ifdef CSA_FINAL_ADDER_STATS_EN
    // Completed-transaction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csa_final_adder_seq.sv
// Self-checking bench for csa_final_adder_seq: an 8/4 instance exercised with
// directed and random operand pairs plus backpressure and mid-op reset, and a
// 16/4 instance fed with carry-save reductions of three random words whose
// expected result is simply the plain sum of the three words.
module tb_csa_final_adder_seq;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   handshakes8 = 0;
    int   handshakes16 = 0;

    always #5 clk = ~clk;

    csa_final_adder_seq_if #(.WIDTH(8))  bus8  ();
    csa_final_adder_seq_if #(.WIDTH(16)) bus16 ();

`ifdef CSA_FINAL_ADDER_STATS_EN
    logic [15:0] op_count8;
    logic [15:0] op_count16;
`endif

    csa_final_adder_seq #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
`ifdef CSA_FINAL_ADDER_STATS_EN
        ,
        .op_count (op_count8)
`endif
    );

    csa_final_adder_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
`ifdef CSA_FINAL_ADDER_STATS_EN
        ,
        .op_count (op_count16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    // One 8-bit transaction; result held for 'hold' cycles under backpressure
    // while junk is offered on the input side.
    task automatic run8(input logic [7:0] s, input logic [7:0] c, input int hold);
        logic [9:0] exp_res;
        int lat;
        exp_res = 10'(s) + 10'(c) * 10'd2;
        check("in_ready_idle", 32'(bus8.in_ready), 1);
        bus8.in_valid = 1'b1;
        bus8.sum_in   = s;
        bus8.carry_in = c;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        bus8.sum_in   = 8'($urandom);
        bus8.carry_in = 8'($urandom);
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            check("busy", 32'(bus8.busy), 1);
            check("in_ready_busy", 32'(bus8.in_ready), 0);
            @(negedge clk);
            lat++;
        end
        check("latency8", 32'(lat), 2);
        check("result8", 32'(bus8.result), 32'(exp_res));
        check("busy_done", 32'(bus8.busy), 0);
        check("in_ready_done", 32'(bus8.in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            bus8.in_valid = 1'b1;
            bus8.sum_in   = 8'($urandom);
            bus8.carry_in = 8'($urandom);
            @(negedge clk);
            check("hold_valid", 32'(bus8.out_valid), 1);
            check("hold_result", 32'(bus8.result), 32'(exp_res));
            check("hold_in_ready", 32'(bus8.in_ready), 0);
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        bus8.out_ready = 1'b0;
        handshakes8++;
        check("out_valid_drop", 32'(bus8.out_valid), 0);
        check("in_ready_back", 32'(bus8.in_ready), 1);
        check("result_kept", 32'(bus8.result), 32'(exp_res));
    endtask

    // One 16-bit transaction built from a carry-save reduction of x,y,z.
    task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        logic [17:0] exp_res;
        int lat;
        int nbusy;
        exp_res = 18'(x) + 18'(y) + 18'(z);
        bus16.sum_in   = x ^ y ^ z;
        bus16.carry_in = (x & y) | (x & z) | (y & z);
        bus16.in_valid = 1'b1;
        @(negedge clk);
        bus16.in_valid = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!bus16.out_valid && lat < 40) begin
            if (bus16.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("latency16", 32'(lat), 4);
        check("busy_cycles16", 32'(nbusy), 4);
        check("busy16_done", 32'(bus16.busy), 0);
        check("result16", 32'(bus16.result), 32'(exp_res));
        bus16.out_ready = 1'b1;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        handshakes16++;
        check("out_valid16_drop", 32'(bus16.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0; bus8.sum_in  = '0; bus8.carry_in  = '0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; bus16.sum_in = '0; bus16.carry_in = '0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_result", 32'(bus8.result), 0);
        check("rst_in_ready", 32'(bus8.in_ready), 1);
        check("rst_in_ready16", 32'(bus16.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // directed: CSA of A3,D2,DD; all-ones; backpressure with junk input
        run8(8'hAC, 8'hD3, 0);
        run8(8'hFF, 8'hFF, 0);
        check("max_top_bits", 32'(bus8.result[9:8]), 32'(2'b10));
        run8(8'($urandom), 8'($urandom), 5);

        // reset in the first busy cycle discards the operation
        bus8.in_valid = 1'b1;
        bus8.sum_in   = 8'h5A;
        bus8.carry_in = 8'hC3;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        check("midop_busy", 32'(bus8.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        handshakes8  = 0;
        handshakes16 = 0;
        check("midop_out_valid", 32'(bus8.out_valid), 0);
        check("midop_busy_clr", 32'(bus8.busy), 0);
        check("midop_result", 32'(bus8.result), 0);
        check("midop_in_ready", 32'(bus8.in_ready), 1);
        run8(8'h5A, 8'hC3, 1);

        for (int i = 0; i < 20; i++) begin
            run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        run16(16'd4231, 16'd7642, 16'd3254);
        check("result16_directed", 32'(bus16.result), 32'd15127);
        run16(16'hFFFF, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 8; i++) begin
            run16(16'($urandom), 16'($urandom), 16'($urandom));
        end

`ifdef CSA_FINAL_ADDER_STATS_EN
        check("op_count8", 32'(op_count8), 32'(handshakes8));
        check("op_count16", 32'(op_count16), 32'(handshakes16));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
